// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple of full-adder / full-subtractor cells.
module addsub_digit
  import addsub_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             mode,
  input  logic             cbin,
  output logic [DIGIT-1:0] s,
  output logic             cbout,
  output logic             c_into_msb
);

  logic [DIGIT:0] cb;

  always_comb begin
    cb    = '0;
    s     = '0;
    cb[0] = cbin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s[i] = x[i] ^ y[i] ^ cb[i];
      if (mode == MODE_SUB)
        cb[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & cb[i]);
      else
        cb[i+1] = (x[i] & y[i]) | ((x[i] ^ y[i]) & cb[i]);
    end
  end

  assign cbout      = cb[DIGIT];
  assign c_into_msb = cb[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial N-bit adder/subtractor: DIGIT bits per clock, LSB first,
// start/busy/done handshake; outputs update only when an operation completes.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(NDIG) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, result_sh, res_next;
  logic             mode_q, cb_q;
  logic [DIGIT-1:0] dig_s;
  logic             dig_cbout, dig_c_msb;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .x         (a_sh[DIGIT-1:0]),
    .y         (b_sh[DIGIT-1:0]),
    .mode      (mode_q),
    .cbin      (cb_q),
    .s         (dig_s),
    .cbout     (dig_cbout),
    .c_into_msb(dig_c_msb)
  );

  // New digit enters at the top; after NDIG steps the first digit sits at bit 0.
  assign res_next = WIDTH'({dig_s, result_sh} >> DIGIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      result_sh <= '0;
      mode_q    <= MODE_ADD;
      cb_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            mode_q <= mode;
            cb_q   <= cin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh      <= a_sh >> DIGIT;
          b_sh      <= b_sh >> DIGIT;
          result_sh <= res_next;
          cb_q      <= dig_cbout;
          cnt       <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= res_next;
            cout   <= dig_cbout;
            ovf    <= dig_c_msb ^ dig_cbout;
            zero   <= (res_next == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
